i2c_master_param: RTL and testbench

- Parametrised successor of the single-shot CPU-side I2C controller.
- Issues one complete I2C master transaction per START_STB: START, address+R/W, 0..MAX_BYTES data bytes (write or read), STOP.
- Checks target ACK on every written byte and generates master ACK/NACK on reads.
- Sits between the CPU register interface and the SDA/SCL pad logic; the SCL rate is derived from CLK by a programmable divider.

---
 rtl/i2c_master_param.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_i2c_master_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_param.sv
// Parametrised single-transaction I2C master: START, address+R/W, 0..MAX_BYTES data bytes, STOP.
// Optional target clock stretching on SCL_IN is enabled by defining CLK_STRETCH_EN.
module i2c_master_param #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MAX_BYTES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START_STB,
    input  logic                   RNW,
    input  logic [6:0]             I2C_ADDR,
    input  logic [3:0]             BYTE_CNT,
    input  logic [8*MAX_BYTES-1:0] WR_DATA,
    input  logic                   SDA_IN,
`ifdef CLK_STRETCH_EN
    input  logic                   SCL_IN,
`endif
    output logic                   SDA_OUT,
    output logic                   SDA_OE,
    output logic                   SCL,
    output logic [8*MAX_BYTES-1:0] RD_DATA,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   NACK
);

    localparam int unsigned DW    = 8 * MAX_BYTES;
    localparam int unsigned QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW    = $clog2(DW);
    localparam logic [3:0]  MAXB4 = 4'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      byte_q, byte_d;
    logic            rnw_q, rnw_d;
    logic [6:0]      addr_q, addr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            samp_q, samp_d;
    logic            scl_q, scl_d;
    logic            sda_out_q, sda_out_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            nack_q, nack_d;

    logic            stall;
    logic            q_first;
    logic            q_last;
    logic            slot_end;
    logic            start_acc;
    logic [7:0]      addr_byte;

    // Bit position of (byte, bit) inside the payload vectors; byte 0 occupies the MSBs.
    function automatic logic [IW-1:0] bit_idx(input logic [3:0] byte_i, input logic [2:0] bit_i);
        return IW'(8 * (MAX_BYTES - 1 - 32'(byte_i)) + 32'(bit_i));
    endfunction

    // Quarter-period timing and optional stretch hold during the SCL-high Q2 quarter.
    always_comb begin
        stall = 1'b0;
`ifdef CLK_STRETCH_EN
        stall = (state_q inside {ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP})
                && (phase_q == 2'd2) && !SCL_IN;
`endif
        q_first  = (qcnt_q == '0);
        q_last   = (qcnt_q == QW'(CLK_DIV - 1));
        slot_end = (state_q != IDLE) && !stall && q_last && (phase_q == 2'd3);
        addr_byte = {addr_q, rnw_q};
    end

    // Next-state, counters, data path and pad values.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        samp_d    = samp_q;
        scl_d     = scl_q;
        sda_out_d = sda_out_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nack_d    = nack_q;
        start_acc = 1'b0;

        if (state_q != IDLE) begin
            if (stall) begin
                qcnt_d = '0;
            end else if (q_last) begin
                qcnt_d  = '0;
                phase_d = 2'(phase_q + 2'd1);
            end else begin
                qcnt_d = QW'(qcnt_q + 1'b1);
            end
            if (phase_q == 2'd3 && q_first) begin
                samp_d = SDA_IN;
            end
        end

        case (state_q)
            IDLE: begin
                if (START_STB) begin
                    start_acc = 1'b1;
                    rnw_d     = RNW;
                    addr_d    = I2C_ADDR;
                    cnt_d     = (BYTE_CNT > MAXB4) ? MAXB4 : BYTE_CNT;
                    wdata_d   = WR_DATA;
                    rdata_d   = '0;
                    nack_d    = 1'b0;
                    busy_d    = 1'b1;
                    qcnt_d    = '0;
                    phase_d   = 2'd0;
                    bit_d     = 3'd7;
                    byte_d    = 4'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (slot_end) begin
                    bit_d   = 3'd7;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = ADDR_ACK;
                    else               bit_d   = 3'(bit_q - 3'd1);
                end
            end
            ADDR_ACK: begin
                if (slot_end) begin
                    bit_d = 3'd7;
                    if (samp_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if (cnt_q == 4'd0) begin
                        state_d = STOP;
                    end else if (rnw_q) begin
                        state_d = RD_BYTE;
                    end else begin
                        state_d = WR_BYTE;
                    end
                end
            end
            WR_BYTE: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = WR_ACK;
                    else               bit_d   = 3'(bit_q - 3'd1);
                end
            end
            WR_ACK: begin
                if (slot_end) begin
                    bit_d = 3'd7;
                    if (samp_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        byte_d  = 4'(byte_q + 4'd1);
                        state_d = (4'(byte_q + 4'd1) == cnt_q) ? STOP : WR_BYTE;
                    end
                end
            end
            RD_BYTE: begin
                if (phase_q == 2'd3 && q_first) begin
                    rdata_d[bit_idx(byte_q, bit_q)] = SDA_IN;
                end
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = RD_ACK;
                    else               bit_d   = 3'(bit_q - 3'd1);
                end
            end
            RD_ACK: begin
                if (slot_end) begin
                    bit_d   = 3'd7;
                    byte_d  = 4'(byte_q + 4'd1);
                    state_d = (4'(byte_q + 4'd1) == cnt_q) ? STOP : RD_BYTE;
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    byte_d  = 4'd0;
                    bit_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // SCL follows the phase of the slot being entered; held high outside bit slots.
        scl_d = 1'b1;
        if (state_d inside {ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP}) begin
            scl_d = phase_d[1];
        end

        // SDA is updated at the first cycle of each slot, except the START/STOP edges.
        if (slot_end || start_acc) begin
            case (state_d)
                ADDR: begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = addr_byte[bit_d];
                end
                WR_BYTE: begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = wdata_q[bit_idx(byte_d, bit_d)];
                end
                ADDR_ACK, WR_ACK, RD_BYTE: begin
                    sda_oe_d  = 1'b0;
                    sda_out_d = 1'b1;
                end
                RD_ACK: begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = (4'(byte_d + 4'd1) == cnt_q);
                end
                STOP: begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = 1'b0;
                end
                default: begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = 1'b1;
                end
            endcase
        end
        if (state_q == START && phase_q == 2'd1 && phase_d == 2'd2) begin
            sda_out_d = 1'b0;
        end
        if (state_q == STOP && phase_q == 2'd2 && phase_d == 2'd3) begin
            sda_out_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 4'd0;
            rnw_q     <= 1'b0;
            addr_q    <= 7'd0;
            cnt_q     <= 4'd0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            samp_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_out_q <= 1'b1;
            sda_oe_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            samp_q    <= samp_d;
            scl_q     <= scl_d;
            sda_out_q <= sda_out_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
        end
    end

    assign SDA_OUT = sda_out_q;
    assign SDA_OE  = sda_oe_q;
    assign SCL     = scl_q;
    assign RD_DATA = rdata_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign NACK    = nack_q;

endmodule

// File: tb/tb_i2c_master_param.sv
// Directed bench for i2c_master_param: a small I2C target model drives SDA_IN and the
// bus is decoded into frames from SCL/SDA; expected values are hand-computed constants.
module tb_i2c_master_param;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned MAX_BYTES = 2;
    localparam int unsigned DW        = 8 * MAX_BYTES;

    logic          CLK       = 1'b0;
    logic          RESET     = 1'b1;
    logic          START_STB = 1'b0;
    logic          RNW       = 1'b0;
    logic [6:0]    I2C_ADDR  = 7'd0;
    logic [3:0]    BYTE_CNT  = 4'd0;
    logic [DW-1:0] WR_DATA   = '0;
    logic          SDA_IN;
    logic          SDA_OUT;
    logic          SDA_OE;
    logic          SCL;
    logic [DW-1:0] RD_DATA;
    logic          BUSY;
    logic          DONE;
    logic          NACK;

    logic          tgt_sda = 1'b1;
    logic          sda_line;
    logic          tb_rnw = 1'b0;
    logic          tb_addr_nack = 1'b0;
    logic [DW-1:0] tb_rd_word = 16'hC381;

    logic          scl_prev = 1'b1;
    logic          sda_prev = 1'b1;
    int            pcnt = 0;
    int            start_cnt = 0;
    int            stop_cnt = 0;
    int            done_cnt = 0;
    logic          bits [0:127];

    int            errors = 0;
    int            checks = 0;

`ifdef CLK_STRETCH_EN
    logic          scl_in_tb;
    logic          stretch_arm = 1'b0;
    int            hold_left = 0;
    assign scl_in_tb = SCL && (hold_left == 0);
`endif

    assign sda_line = SDA_OE ? SDA_OUT : tgt_sda;
    assign SDA_IN   = sda_line;

    always #5 CLK = ~CLK;

    i2c_master_param #(
        .CLK_DIV   (CLK_DIV),
        .MAX_BYTES (MAX_BYTES)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START_STB (START_STB),
        .RNW       (RNW),
        .I2C_ADDR  (I2C_ADDR),
        .BYTE_CNT  (BYTE_CNT),
        .WR_DATA   (WR_DATA),
        .SDA_IN    (SDA_IN),
`ifdef CLK_STRETCH_EN
        .SCL_IN    (scl_in_tb),
`endif
        .SDA_OUT   (SDA_OUT),
        .SDA_OE    (SDA_OE),
        .SCL       (SCL),
        .RD_DATA   (RD_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .NACK      (NACK)
    );

    // Target drive for the slot following k completed SCL pulses.
    function automatic logic tgt_bit(input int k);
        int pos;
        int g;
        pos = k % 9;
        g   = k / 9;
        if (g == 0) return (pos == 8) ? tb_addr_nack : 1'b1;
        if (!tb_rnw) return (pos == 8) ? 1'b0 : 1'b1;
        if (pos == 8 || g > 2) return 1'b1;
        return tb_rd_word[DW - 1 - 8 * (g - 1) - pos];
    endfunction

    function automatic logic [7:0] frame(input int g);
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[7 - i] = bits[9 * g + 1 + i];
        return f;
    endfunction

    // Bus monitor and target: sampled on the falling CLK edge, away from DUT updates.
    always @(negedge CLK) begin
        scl_prev <= SCL;
        sda_prev <= sda_line;
        if (DONE) done_cnt <= done_cnt + 1;
        if (scl_prev && SCL && sda_prev && !sda_line) begin
            start_cnt <= start_cnt + 1;
            pcnt      <= 0;
        end else if (scl_prev && SCL && !sda_prev && sda_line) begin
            stop_cnt <= stop_cnt + 1;
        end
        if (!scl_prev && SCL) begin
            pcnt <= pcnt + 1;
            if (pcnt < 120) bits[pcnt + 1] <= sda_line;
        end
        if (scl_prev && !SCL) tgt_sda <= tgt_bit(pcnt);
`ifdef CLK_STRETCH_EN
        if (!scl_prev && SCL && stretch_arm && pcnt == 4) hold_left <= 20;
        else if (hold_left != 0) hold_left <= hold_left - 1;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic rnw, input logic [6:0] addr, input logic [3:0] cnt,
                           input logic [DW-1:0] wd, input bit inject, output int cycles);
        int  d0;
        bit  seen;
        d0     = done_cnt;
        seen   = 1'b0;
        cycles = 0;
        @(negedge CLK);
        RNW       = rnw;
        I2C_ADDR  = addr;
        BYTE_CNT  = cnt;
        WR_DATA   = wd;
        tb_rnw    = rnw;
        START_STB = 1'b1;
        @(negedge CLK);
        START_STB = 1'b0;
        check_eq("busy_after_stb", 32'(BUSY), 32'd1);
        for (int n = 1; n < 3000 && !seen; n++) begin
            if (inject && n == 100) begin
                START_STB = 1'b1;
                RNW       = ~rnw;
                I2C_ADDR  = 7'h11;
                BYTE_CNT  = 4'd1;
                WR_DATA   = '1;
            end else begin
                START_STB = 1'b0;
            end
            @(negedge CLK);
            if (DONE) begin
                seen   = 1'b1;
                cycles = n;
                check_eq("busy_at_done", 32'(BUSY), 32'd0);
            end
        end
        START_STB = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        @(negedge CLK);
        check_eq("done_one_cycle", 32'(DONE), 32'd0);
        check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int  cyc_w;
        int  cyc;
        int  s0;
        int  d0;
        bit  reached;

        #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_scl", 32'(SCL), 32'd1);
        check_eq("rst_sda_out", 32'(SDA_OUT), 32'd1);
        check_eq("rst_sda_oe", 32'(SDA_OE), 32'd1);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        check_eq("rst_nack", 32'(NACK), 32'd0);
        check_eq("rst_rd_data", 32'(RD_DATA), 32'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Two-byte write, all ACKed
        s0 = stop_cnt;
        run_txn(1'b0, 7'h50, 4'd2, 16'hA55A, 1'b0, cyc_w);
        check_eq("wr_frame0", 32'(frame(0)), 32'hA0);
        check_eq("wr_frame1", 32'(frame(1)), 32'hA5);
        check_eq("wr_frame2", 32'(frame(2)), 32'h5A);
        check_eq("wr_ack0", 32'(bits[9]), 32'd0);
        check_eq("wr_ack2", 32'(bits[27]), 32'd0);
        check_eq("wr_pulses", 32'(pcnt), 32'd28);
        check_eq("wr_stop", 32'(stop_cnt - s0), 32'd1);
        check_eq("wr_nack", 32'(NACK), 32'd0);
        check_eq("wr_busy_after", 32'(BUSY), 32'd0);

        // Two-byte read with master ACK then NACK
        run_txn(1'b1, 7'h3C, 4'd2, 16'h0000, 1'b0, cyc);
        check_eq("rd_frame0", 32'(frame(0)), 32'h79);
        check_eq("rd_data", 32'(RD_DATA), 32'hC381);
        check_eq("rd_mack0", 32'(bits[18]), 32'd0);
        check_eq("rd_mack1", 32'(bits[27]), 32'd1);
        check_eq("rd_pulses", 32'(pcnt), 32'd28);
        check_eq("rd_nack", 32'(NACK), 32'd0);

        // Address NACK
        tb_addr_nack = 1'b1;
        run_txn(1'b0, 7'h2A, 4'd2, 16'h1234, 1'b0, cyc);
        tb_addr_nack = 1'b0;
        check_eq("an_nack", 32'(NACK), 32'd1);
        check_eq("an_pulses", 32'(pcnt), 32'd10);
        check_eq("an_ackbit", 32'(bits[9]), 32'd1);
        check_eq("an_rd_cleared", 32'(RD_DATA), 32'd0);

        // Address-only transaction
        run_txn(1'b0, 7'h13, 4'd0, 16'hFFFF, 1'b0, cyc);
        check_eq("c0_nack_cleared", 32'(NACK), 32'd0);
        check_eq("c0_pulses", 32'(pcnt), 32'd10);
        check_eq("c0_frame0", 32'(frame(0)), 32'h26);

        // Oversized count clamps to MAX_BYTES
        run_txn(1'b0, 7'h50, 4'd9, 16'h0FF0, 1'b0, cyc);
        check_eq("c9_pulses", 32'(pcnt), 32'd28);
        check_eq("c9_frame1", 32'(frame(1)), 32'h0F);
        check_eq("c9_frame2", 32'(frame(2)), 32'hF0);

        // Strobe and input changes mid-transfer are ignored
        run_txn(1'b0, 7'h50, 4'd2, 16'hA55A, 1'b1, cyc);
        check_eq("inj_frame0", 32'(frame(0)), 32'hA0);
        check_eq("inj_frame1", 32'(frame(1)), 32'hA5);
        check_eq("inj_frame2", 32'(frame(2)), 32'h5A);
        check_eq("inj_pulses", 32'(pcnt), 32'd28);
        check_eq("inj_cycles", 32'(cyc), 32'(cyc_w));

        // Asynchronous reset in the first data byte
        d0 = done_cnt;
        @(negedge CLK);
        RNW = 1'b0; I2C_ADDR = 7'h50; BYTE_CNT = 4'd2; WR_DATA = 16'hA55A;
        tb_rnw = 1'b0;
        START_STB = 1'b1;
        @(negedge CLK);
        START_STB = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            @(negedge CLK);
            if (pcnt >= 12) reached = 1'b1;
        end
        check_eq("mr_reached_wr_byte", 32'(reached), 32'd1);
        #2 RESET = 1'b0;
        #1;
        check_eq("mr_scl", 32'(SCL), 32'd1);
        check_eq("mr_sda_oe", 32'(SDA_OE), 32'd1);
        check_eq("mr_sda_out", 32'(SDA_OUT), 32'd1);
        check_eq("mr_busy", 32'(BUSY), 32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (20) @(negedge CLK);
        check_eq("mr_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("mr_idle_busy", 32'(BUSY), 32'd0);

`ifdef CLK_STRETCH_EN
        // Target holds SCL low for 20 cycles in Q2 of address bit 3
        stretch_arm = 1'b1;
        run_txn(1'b0, 7'h50, 4'd2, 16'hA55A, 1'b0, cyc);
        stretch_arm = 1'b0;
        check_eq("st_extra_cycles", 32'(cyc - cyc_w), 32'd20);
        check_eq("st_frame0", 32'(frame(0)), 32'hA0);
        check_eq("st_frame1", 32'(frame(1)), 32'hA5);
        check_eq("st_frame2", 32'(frame(2)), 32'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
